// File: rtl/sync_fifo_param.sv
// Single-clock parametrised FIFO with occupancy count, thresholds,
// standard or first-word-fall-through read mode and sticky error flags.
module sync_fifo_param #(
    parameter int DATAWIDTH = 8,
    parameter int ADDRWIDTH = 4,
    parameter int AFULL_TH  = 12,
    parameter int AEMPT_TH  = 4,
    parameter int FWFT      = 0
) (
    input  logic                 iCLK,
    input  logic                 iRST,
    input  logic [DATAWIDTH-1:0] iWDAT,
    input  logic                 iWINC,
    output logic                 oFULL,
    output logic                 oAFULL,
    input  logic                 iRINC,
    output logic [DATAWIDTH-1:0] oRDAT,
    output logic                 oEMPT,
    output logic                 oAEMPT,
    output logic [ADDRWIDTH:0]   oCNT,
    output logic                 oOVF,
    output logic                 oUDF,
    input  logic                 iCLRERR
);

    localparam int DEPTH = 2 ** ADDRWIDTH;
    localparam logic [ADDRWIDTH:0] DEPTH_C = (ADDRWIDTH+1)'(DEPTH);
    localparam logic [ADDRWIDTH:0] AF_C    = (ADDRWIDTH+1)'(AFULL_TH);
    localparam logic [ADDRWIDTH:0] AE_C    = (ADDRWIDTH+1)'(AEMPT_TH);

    logic [DATAWIDTH-1:0] mem [DEPTH];
    logic [ADDRWIDTH-1:0] wptr;
    logic [ADDRWIDTH-1:0] rptr;
    logic [ADDRWIDTH:0]   cnt;
    logic                 full;
    logic                 empt;
    logic                 wr_ok;
    logic                 rd_ok;

    // Flags decode only the registered count, so acceptance never
    // depends combinationally on the same-cycle request of the other side.
    assign full   = (cnt == DEPTH_C);
    assign empt   = (cnt == '0);
    assign wr_ok  = iWINC & ~full;
    assign rd_ok  = iRINC & ~empt;

    assign oFULL  = full;
    assign oEMPT  = empt;
    assign oAFULL = (cnt >= AF_C);
    assign oAEMPT = (cnt <= AE_C);
    assign oCNT   = cnt;

    // Storage is deliberately left uncleared by reset.
    always_ff @(posedge iCLK) begin
        if (!iRST && wr_ok) begin
            mem[wptr] <= iWDAT;
        end
    end

    // Pointers and occupancy; wrap is the natural ADDRWIDTH overflow.
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
        end else begin
            if (wr_ok) begin
                wptr <= wptr + 1'b1;
            end
            if (rd_ok) begin
                rptr <= rptr + 1'b1;
            end
            unique case ({wr_ok, rd_ok})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    // Sticky errors; a new error in the clearing cycle keeps the flag set.
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            oOVF <= 1'b0;
            oUDF <= 1'b0;
        end else begin
            oOVF <= (iWINC & full) | (oOVF & ~iCLRERR);
            oUDF <= (iRINC & empt) | (oUDF & ~iCLRERR);
        end
    end

    generate
        if (FWFT != 0) begin : g_fwft
            assign oRDAT = mem[rptr];
        end else begin : g_std
            logic [DATAWIDTH-1:0] rdat;
            // Registered read port, loaded only on an accepted read.
            always_ff @(posedge iCLK) begin
                if (iRST) begin
                    rdat <= '0;
                end else if (rd_ok) begin
                    rdat <= mem[rptr];
                end
            end
            assign oRDAT = rdat;
        end
    endgenerate

endmodule

// File: tb/tb_sync_fifo_param.sv
// Bench for sync_fifo_param: standard-mode scoreboard run plus a
// small directed check of an FWFT instance.
module tb_sync_fifo_param;

    logic       clk = 1'b0;
    logic       rst, winc, rinc, clr;
    logic [7:0] wdat, rdat;
    logic       full, afull, empt, aempt, ovf, udf;
    logic [4:0] cnt;

    logic       f_rst, f_winc, f_rinc, f_clr;
    logic [7:0] f_wdat, f_rdat;
    logic       f_full, f_afull, f_empt, f_aempt, f_ovf, f_udf;
    logic [4:0] f_cnt;

    int checks = 0;
    int errors = 0;

    logic [7:0] m_q [$];
    logic [7:0] exp_q [$];
    int         m_cnt = 0;
    logic       m_ovf = 1'b0, m_udf = 1'b0;
    logic [7:0] m_rdat = 8'h00;
    logic       m_valid = 1'b0;
    logic       rd_tag = 1'b0;
    logic       done = 1'b0;

    always #5 clk = ~clk;

    sync_fifo_param #(.FWFT(0)) dut (
        .iCLK(clk), .iRST(rst), .iWDAT(wdat), .iWINC(winc),
        .oFULL(full), .oAFULL(afull), .iRINC(rinc), .oRDAT(rdat),
        .oEMPT(empt), .oAEMPT(aempt), .oCNT(cnt), .oOVF(ovf),
        .oUDF(udf), .iCLRERR(clr)
    );

    sync_fifo_param #(.FWFT(1)) dut_f (
        .iCLK(clk), .iRST(f_rst), .iWDAT(f_wdat), .iWINC(f_winc),
        .oFULL(f_full), .oAFULL(f_afull), .iRINC(f_rinc), .oRDAT(f_rdat),
        .oEMPT(f_empt), .oAEMPT(f_aempt), .oCNT(f_cnt), .oOVF(f_ovf),
        .oUDF(f_udf), .iCLRERR(f_clr)
    );

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h @%0t", name, act, exp, $time);
        end
    endtask

    // Monitor: one edge after an accepted read, the head word must appear.
    always @(posedge clk) begin
        logic tag;
        logic [7:0] e;
        tag = rd_tag;
        #1;
        if (tag) begin
            if (exp_q.size() == 0) begin
                chk("sb_underrun", 1, 0);
            end else begin
                e = exp_q.pop_front();
                chk("sb_rdat", {24'h0, rdat}, {24'h0, e});
            end
        end
    end

    task automatic check_state();
        chk("cnt",   {27'h0, cnt},   m_cnt);
        chk("full",  {31'h0, full},  (m_cnt == 16) ? 1 : 0);
        chk("empt",  {31'h0, empt},  (m_cnt == 0) ? 1 : 0);
        chk("afull", {31'h0, afull}, (m_cnt >= 12) ? 1 : 0);
        chk("aempt", {31'h0, aempt}, (m_cnt <= 4) ? 1 : 0);
        chk("ovf",   {31'h0, ovf},   {31'h0, m_ovf});
        chk("udf",   {31'h0, udf},   {31'h0, m_udf});
        chk("rdat_hold", {24'h0, rdat}, {24'h0, m_rdat});
    endtask

    task automatic step(input logic w, input logic [7:0] d,
                        input logic r, input logic c, input logic rs);
        logic wa, ra;
        @(negedge clk);
        if (m_valid) check_state();
        rst = rs; winc = w; wdat = d; rinc = r; clr = c;
        if (rs) begin
            m_q.delete();
            m_cnt = 0; m_ovf = 0; m_udf = 0; m_rdat = 8'h00;
            rd_tag = 1'b0;
            m_valid = 1'b1;
        end else begin
            wa = w && (m_cnt < 16);
            ra = r && (m_cnt > 0);
            m_ovf = (w && m_cnt == 16) || (m_ovf && !c);
            m_udf = (r && m_cnt == 0) || (m_udf && !c);
            rd_tag = ra;
            if (ra) begin
                m_rdat = m_q.pop_front();
                exp_q.push_back(m_rdat);
            end
            if (wa) m_q.push_back(d);
            m_cnt = m_cnt + (wa ? 1 : 0) - (ra ? 1 : 0);
        end
    endtask

    initial begin
        rst = 1'b1; winc = 0; rinc = 0; clr = 0; wdat = 0;
        f_rst = 1'b1; f_winc = 0; f_rinc = 0; f_clr = 0; f_wdat = 0;

        step(0, 0, 0, 0, 1);
        for (int i = 1; i <= 16; i++) step(1, 8'(i), 0, 0, 0);
        step(1, 8'hAA, 1, 0, 0);
        for (int i = 0; i < 15; i++) step(0, 0, 1, 0, 0);
        step(0, 0, 1, 0, 0);
        step(0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0);
        for (int i = 0; i < 8; i++) step(1, 8'h20 + 8'(i), 0, 0, 0);
        for (int i = 8; i < 48; i++) step(1, 8'h20 + 8'(i), 1, 0, 0);
        for (int i = 0; i < 8; i++) step(0, 0, 1, 0, 0);
        for (int i = 0; i < 9; i++) step(1, 8'hC0 + 8'(i), 0, 0, 0);
        step(1, 8'hEE, 0, 0, 1);
        for (int i = 0; i < 3; i++) step(1, 8'h70 + 8'(i), 0, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        repeat (2) @(negedge clk);
        chk("sb_drained", exp_q.size(), 0);
        done = 1'b1;
    end

    initial begin
        repeat (2) @(negedge clk);
        f_rst = 1'b0;
        @(negedge clk);
        chk("f_empt_rst", {31'h0, f_empt}, 1);
        f_winc = 1; f_wdat = 8'h5A;
        @(negedge clk);
        f_winc = 0;
        chk("f_empt_fall", {31'h0, f_empt}, 0);
        chk("f_head", {24'h0, f_rdat}, 32'h5A);
        f_winc = 1; f_wdat = 8'h3C;
        @(negedge clk);
        f_winc = 0;
        chk("f_head_keep", {24'h0, f_rdat}, 32'h5A);
        chk("f_cnt2", {27'h0, f_cnt}, 2);
        f_rinc = 1;
        @(negedge clk);
        chk("f_head2", {24'h0, f_rdat}, 32'h3C);
        @(negedge clk);
        f_rinc = 0;
        chk("f_empt_pop", {31'h0, f_empt}, 1);
        chk("f_udf", {31'h0, f_udf}, 0);
    end

    initial begin
        fork
            wait (done);
            begin
                repeat (2000) @(posedge clk);
                chk("timeout", 1, 0);
            end
        join_any
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
